serial_load_32: RTL and testbench
=================================

Name: serial_load_32

Overview:
- Serial-to-parallel receiver: the counterpart of the 32-bit parallel-load/serial-shift register used by the datapath.
- Collects a framed serial bit stream, one bit per qualified clock, MSB-first or LSB-first.
- Presents each completed word on a held parallel output with a valid/ack handshake.
- Feeds the parallel-data input of the datapath blocks; reports framing and overrun errors.

Parameters:
- WIDTH, 32, word length in bits; legal range is 2 or more.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset, synchronous, active-high; overrides every other input.
- bit_en  in  1  qualifies SI and sof for this cycle.
- sof  in  1  start of frame; meaningful only when bit_en=1; marks SI as the first bit of a word.
- SI  in  1  serial data bit.
- dir  in  1  0 = MSB-first, 1 = LSB-first; sampled only on the start bit.
- ack  in  1  consumer accepts PData; meaningful only while valid=1.
- PData  out  WIDTH  holding register; the last delivered word.
- valid  out  1  PData holds an unconsumed word.
- busy  out  1  a frame is in progress (state RECV).
- frame_err  out  1  sticky: a frame was aborted by sof.
- overrun  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset (clear=1 at an edge): state IDLE; shift register=0; counter=0; PData=0; valid=0; busy=0; frame_err=0; overrun=0. Applies mid-frame; the partial word is discarded and no flag is set.
- Shift rule, dir latched = 0 (shift left): sreg <= {sreg[WIDTH-2:0], SI}. The first bit ends in bit WIDTH-1.
- Shift rule, dir latched = 1 (shift right): sreg <= {SI, sreg[WIDTH-1:1]}. The first bit ends in bit 0.
- State IDLE:
  - bit_en&sof: latch dir, shift SI into a zero-cleared sreg, counter=1, go to RECV.
  - bit_en without sof: ignored.
- State RECV:
  - bit_en&!sof: shift, counter+1.
  - The 32nd bit completes the word when bit_en=1 and counter=WIDTH-1. Deliver the word including this bit, return to IDLE, counter=0.
  - bit_en&sof: abort the frame. Set frame_err, restart as a start bit (latch dir, counter=1), stay in RECV.
  - bit_en=0: hold all state. There is no timeout.
- Delivery: the completed word is written to PData at the same edge that samples the final bit. valid=1 is visible in the following cycle, so latency is one cycle from final-bit sampling to valid.
- Handshake:
  - A word is consumed at an edge with valid&ack; valid falls at that edge unless a new word is delivered at the same edge.
  - PData is stable while valid=1.
  - ack while valid=0 has no effect.
- Simultaneous completion and ack: the new word loads, valid stays 1, no overrun.
- Completion while valid=1 and ack=0: the new word is dropped, PData and valid are unchanged, overrun is set.
- WIDTH=2: the second bit completes the word; no special-case path.
- busy equals (state==RECV), registered.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, RECV=1'b1;
  - direction constants DIR_MSB=0, DIR_LSB=1;
  - default WIDTH/CNT_W.
- One natural sub-module, serial_load_shreg: the WIDTH-bit bidirectional shift register with synchronous zero-load, shift-left and shift-right controls.
- The FSM, counter, holding register and handshake live in the top module.

Test Plan:
- MSB-first: sof on the first bit, dir=0, send 0xDEADBEEF bits 31..0 on 32 consecutive bit_en cycles, ack=0. Expect PData=0xDEADBEEF and valid=1 the cycle after the 32nd bit, busy=0, flags 0.
- LSB-first with gaps: dir=1, send 0x12345678 bit 0 first, bit_en low on random cycles. Expect PData=0x12345678; state holds during gaps.
- Overrun and simultaneous ack:
  - Deliver 0xA5A5A5A5 and hold ack=0. Send 0x0F0F0F0F. Expect PData still 0xA5A5A5A5, overrun=1.
  - Next word 0xFFFF0000 with ack=1 at its completion edge. Expect PData=0xFFFF0000, valid stays 1.
- Abort: send 10 bits of a frame, then sof with bit_en, then a full 0xCAFEF00D. Expect frame_err=1 and PData=0xCAFEF00D; the first 10 bits have no effect.
- Reset mid-frame: clear=1 after 20 bits. Next edge: PData=0, valid=0, busy=0, flags 0. A following complete frame 0x00000001 delivers correctly.
- Idle noise: bit_en pulses without sof in IDLE. Expect no state change, busy=0, valid=0.

Source files
------------

// File: rtl/serial_load_pkg.sv
// Shared constants for the serial-to-parallel receiver: state encoding,
// shift-direction codes and default geometry.
package serial_load_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefCntW  = 6;

  // Receiver FSM encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  // Bit order of a frame, latched from dir on the start bit
  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/serial_load_shreg.sv
// Bidirectional shift register with synchronous zero-load. The next-state value is
// exported so the owner can capture a word together with the bit being shifted in.
module serial_load_shreg
  import serial_load_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             zero_i,
  input  logic             shift_i,
  input  logic             dir_i,
  input  logic             si_i,
  output logic [Width-1:0] word_d_o
);

  logic [Width-1:0] sreg_q, sreg_d, base;

  always_comb begin
    // Zero-load composes with a shift so a start bit lands in a clean register
    base   = zero_i ? '0 : sreg_q;
    sreg_d = base;
    if (shift_i) begin
      if (dir_i == DIR_LSB) begin
        sreg_d = {si_i, base[Width-1:1]};
      end else begin
        sreg_d = {base[Width-2:0], si_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign word_d_o = sreg_d;

endmodule

// File: rtl/serial_load_32.sv
// Framed serial-to-parallel receiver with a held parallel output, valid/ack
// handshake and sticky framing/overrun flags.
module serial_load_32
  import serial_load_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             sof,
  input  logic             SI,
  input  logic             dir,
  input  logic             ack,
  output logic [WIDTH-1:0] PData,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             sr_zero, sr_shift, sr_dir, complete;
  logic [WIDTH-1:0] word_next;

  serial_load_shreg #(
    .Width(WIDTH)
  ) u_shreg (
    .clk_i   (clk),
    .rst_i   (clear),
    .zero_i  (sr_zero),
    .shift_i (sr_shift),
    .dir_i   (sr_dir),
    .si_i    (SI),
    .word_d_o(word_next)
  );

  // Frame sequencing and bit counting
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    ferr_d   = ferr_q;
    sr_zero  = 1'b0;
    sr_shift = 1'b0;
    sr_dir   = dir_q;
    complete = 1'b0;

    if (bit_en && sof) begin
      // A start bit in RECV aborts the current frame and restarts it
      if (state_q == RECV) begin
        ferr_d = 1'b1;
      end
      state_d  = RECV;
      cnt_d    = OneCnt;
      dir_d    = dir;
      sr_dir   = dir;
      sr_zero  = 1'b1;
      sr_shift = 1'b1;
    end else if (bit_en && (state_q == RECV)) begin
      sr_shift = 1'b1;
      if (cnt_q == LastCnt) begin
        complete = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + OneCnt;
      end
    end
  end

  // Holding register and handshake
  always_comb begin
    pdata_d = pdata_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (complete) begin
      if (!valid_q || ack) begin
        pdata_d = word_next;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_MSB;
      pdata_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pdata_q <= pdata_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign PData     = pdata_q;
  assign valid     = valid_q;
  assign busy      = (state_q == RECV);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_load_32.sv
// Scoreboard bench for serial_load_32: expected words are queued as frames are sent
// and popped when the receiver raises valid.
module tb_serial_load_32;

  logic        clk = 1'b0;
  logic        clear, bit_en, sof, SI, dir, ack;
  logic [31:0] PData;
  logic        valid, busy, frame_err, overrun;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  serial_load_32 dut (
    .clk      (clk),
    .clear    (clear),
    .bit_en   (bit_en),
    .sof      (sof),
    .SI       (SI),
    .dir      (dir),
    .ack      (ack),
    .PData    (PData),
    .valid    (valid),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Send a full frame; dir is inverted after the start bit to prove it is latched.
  task automatic send_word(input logic [31:0] w, input logic d, input bit gaps,
                           input logic ack_last);
    for (int i = 0; i < 32; i++) begin
      if (gaps && i > 0) begin
        while ($urandom_range(0, 2) == 0) begin
          bit_en = 1'b0;
          sof    = 1'b0;
          SI     = 1'($urandom_range(0, 1));
          tick();
          check_bit("gap_busy", busy, 1'b1);
        end
      end
      bit_en = 1'b1;
      sof    = (i == 0);
      dir    = (i == 0) ? d : ~d;
      SI     = d ? w[i] : w[31-i];
      ack    = (i == 31) ? ack_last : 1'b0;
      tick();
    end
    bit_en = 1'b0;
    sof    = 1'b0;
    ack    = 1'b0;
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) begin
      bit_en = 1'b1;
      sof    = (i == 0);
      dir    = 1'b0;
      SI     = 1'($urandom_range(0, 1));
      tick();
    end
    bit_en = 1'b0;
    sof    = 1'b0;
  endtask

  task automatic check_out(input string name);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: got empty scoreboard expected one word", name);
    end else begin
      e = exp_q.pop_front();
      check_word({name, "_pdata"}, PData, e);
      check_bit({name, "_valid"}, valid, 1'b1);
    end
  endtask

  task automatic consume(input string name, input logic [31:0] held);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_bit({name, "_valid_drop"}, valid, 1'b0);
    check_word({name, "_pdata_hold"}, PData, held);
  endtask

  task automatic test_reset();
    clear = 1'b1; bit_en = 1'b0; sof = 1'b0; SI = 1'b0; dir = 1'b0; ack = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    check_word("rst_pdata", PData, 32'h0);
    check_bit("rst_valid", valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_ferr", frame_err, 1'b0);
    check_bit("rst_ovr", overrun, 1'b0);
  endtask

  task automatic test_msb_first();
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    check_out("msb");
    check_bit("msb_busy", busy, 1'b0);
    check_bit("msb_ferr", frame_err, 1'b0);
    check_bit("msb_ovr", overrun, 1'b0);
    tick();
    check_word("msb_stable", PData, 32'hDEADBEEF);
    consume("msb", 32'hDEADBEEF);
  endtask

  task automatic test_lsb_gaps();
    exp_q.push_back(32'h12345678);
    send_word(32'h12345678, 1'b1, 1'b1, 1'b0);
    check_out("lsb");
    check_bit("lsb_busy", busy, 1'b0);
    consume("lsb", 32'h12345678);
  endtask

  task automatic test_overrun();
    exp_q.push_back(32'hA5A5A5A5);
    send_word(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    check_out("ovr_first");
    send_word(32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
    check_word("ovr_pdata_kept", PData, 32'hA5A5A5A5);
    check_bit("ovr_valid", valid, 1'b1);
    check_bit("ovr_flag", overrun, 1'b1);
    exp_q.push_back(32'hFFFF0000);
    send_word(32'hFFFF0000, 1'b0, 1'b0, 1'b1);
    check_out("simul_ack");
    check_bit("ovr_sticky", overrun, 1'b1);
    consume("simul", 32'hFFFF0000);
  endtask

  task automatic test_abort();
    send_partial(10);
    check_bit("abort_busy", busy, 1'b1);
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    check_bit("abort_ferr", frame_err, 1'b1);
    check_out("abort");
    consume("abort", 32'hCAFEF00D);
  endtask

  task automatic test_clear_midframe();
    send_partial(20);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_word("clr_pdata", PData, 32'h0);
    check_bit("clr_valid", valid, 1'b0);
    check_bit("clr_busy", busy, 1'b0);
    check_bit("clr_ferr", frame_err, 1'b0);
    check_bit("clr_ovr", overrun, 1'b0);
    exp_q.push_back(32'h00000001);
    send_word(32'h00000001, 1'b0, 1'b0, 1'b0);
    check_out("after_clr");
    consume("after_clr", 32'h00000001);
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 8; i++) begin
      bit_en = 1'b1;
      sof    = 1'b0;
      SI     = 1'($urandom_range(0, 1));
      ack    = 1'($urandom_range(0, 1));
      tick();
      check_bit("noise_busy", busy, 1'b0);
      check_bit("noise_valid", valid, 1'b0);
    end
    bit_en = 1'b0;
    ack    = 1'b0;
    check_word("noise_pdata", PData, 32'h00000001);
    exp_q.push_back(32'h80000001);
    send_word(32'h80000001, 1'b0, 1'b0, 1'b0);
    check_out("post_noise");
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_gaps();
    test_overrun();
    test_abort();
    test_clear_midframe();
    test_idle_noise();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d words left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
